// File: rtl/hash_arb_pkg.sv
// ---------------------------------------------------------------------------
// hash_arb_pkg
// Shared definitions for the hash arbiter slice: the sequencer state
// encoding, the default key/hash widths used by the external name-hash
// engine, and the requester-ID width helper.
// ---------------------------------------------------------------------------
package hash_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HASH = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_HASH_W = 10;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/hash_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Scans the request vector starting at
// ptr and wraps, returning the first asserted requester.
//
// Optional feature (macro HASH_ARB_PRIO0_EN): requester 0 wins outright
// whenever it requests and prio_win flags that the pointer must not move;
// the remaining requesters rotate among themselves.
//
// Ports:
//   req       in   NUM_REQ  request vector
//   ptr       in   ID_W     index searched first
//   grant     out  NUM_REQ  one-hot grant (all zeros when no request)
//   winner    out  ID_W     index of the granted requester
//   any       out  1        at least one request present
//   prio_win  out  1        requester 0 won through strict priority
// ---------------------------------------------------------------------------
module rr_pick
    import hash_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    winner,
    output logic               any,
    output logic               prio_win
);

    logic [NUM_REQ-1:0] rr_req;

`ifdef HASH_ARB_PRIO0_EN
    assign prio_win = req[0];
    assign rr_req   = {req[NUM_REQ-1:1], 1'b0};
`else
    assign prio_win = 1'b0;
    assign rr_req   = req;
`endif

    // One extra bit so ptr + offset can exceed NUM_REQ before wrapping.
    logic [ID_W:0] idx;

    always_comb begin
        // NOTE: every output gets a default before any conditional write,
        // otherwise synthesis infers latches for the unassigned paths.
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        if (prio_win) begin
            grant[0] = 1'b1;
            any      = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = {1'b0, ptr} + (ID_W+1)'(k);
                if (idx >= (ID_W+1)'(NUM_REQ))
                    idx = idx - (ID_W+1)'(NUM_REQ);
                if (!any && rr_req[idx[ID_W-1:0]]) begin
                    any                  = 1'b1;
                    winner               = idx[ID_W-1:0];
                    grant[idx[ID_W-1:0]] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hash_arbiter.sv
// ---------------------------------------------------------------------------
// hash_arbiter
// Shares one external combinational name-hash engine among NUM_REQ lookup
// requesters. IDLE grants one requester (round-robin) and latches its key,
// HASH presents the key to the engine and captures the hash, RESP holds the
// result on the response channel until the consumer accepts it.
// Grant in cycle T gives rsp_valid in T+2; the next grant is possible at T+3.
//
// Optional feature (macro HASH_ARB_PRIO0_EN): strict priority for
// requester 0, implemented in rr_pick.
//
// Ports:
//   clk        in   1               clock, rising edge
//   rst        in   1               asynchronous active-high reset
//   req_valid  in   NUM_REQ         per-requester key valid
//   req_data   in   NUM_REQ*DATA_W  keys, requester i at [i*DATA_W +: DATA_W]
//   req_ready  out  NUM_REQ         one-hot accept, only in IDLE
//   eng_data   out  DATA_W          key driven to the hash engine
//   eng_hash   in   HASH_W          engine result, combinational
//   rsp_valid  out  1               result valid
//   rsp_id     out  ID_W            requester index of the result
//   rsp_hash   out  HASH_W          registered hash
//   rsp_ready  in   1               consumer accepts result
// ---------------------------------------------------------------------------
module hash_arbiter
    import hash_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = DEF_DATA_W,
    parameter  int HASH_W  = DEF_HASH_W,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         eng_data,
    input  logic [HASH_W-1:0]         eng_hash,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [HASH_W-1:0]         rsp_hash,
    input  logic                      rsp_ready
);

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q;
    logic [DATA_W-1:0]   key_q;
    logic [ID_W-1:0]     id_q;
    logic [HASH_W-1:0]   hash_q;

    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     winner;
    logic                any;
    logic                prio_win;
    logic                accept;
    logic [ID_W-1:0]     ptr_inc;

    logic [DATA_W-1:0]   key_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_key
        assign key_arr[i] = req_data[i*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req      (req_valid),
        .ptr      (ptr_q),
        .grant    (grant),
        .winner   (winner),
        .any      (any),
        .prio_win (prio_win)
    );

    assign ptr_inc = (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + ID_W'(1);

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (any) begin
                    req_ready = grant;
                    accept    = 1'b1;
                    state_d   = HASH;
                end
            end
            HASH: state_d = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                // No grant here even with requests pending: keeps the
                // 3-cycle issue interval and a single in-flight key.
                if (rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            key_q   <= '0;
            id_q    <= '0;
            hash_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                key_q <= key_arr[winner];
                id_q  <= winner;
                if (!prio_win)
                    ptr_q <= ptr_inc;
            end
            if (state_q == HASH)
                hash_q <= eng_hash;
        end
    end

    // key_q is held after HASH so the engine input stays quiet in IDLE.
    assign eng_data = key_q;
    assign rsp_id   = id_q;
    assign rsp_hash = hash_q;

endmodule

// File: tb/tb_hash_arbiter.sv
// ---------------------------------------------------------------------------
// tb_hash_arbiter
// Directed bench for hash_arbiter (NUM_REQ=4). Stimulus pushes expected
// {id, hash} responses into a scoreboard queue; a monitor on the falling
// edge pops and compares on every accepted response. The hash engine is
// modelled here: fold the key into 10-bit chunks by XOR, then f ^ (f << 7).
// Expected hashes for the directed keys are written as constants.
// Build with +define+HASH_ARB_PRIO0_EN to check the priority variant.
// ---------------------------------------------------------------------------
module tb_hash_arbiter;
    import hash_arb_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 64;
    localparam int HASH_W  = 10;
    localparam int ID_W    = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         eng_data;
    logic [HASH_W-1:0]         eng_hash;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [HASH_W-1:0]         rsp_hash;
    logic                      rsp_ready;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [HASH_W-1:0] hash;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    hash_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .HASH_W  (HASH_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .eng_data  (eng_data),
        .eng_hash  (eng_hash),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_hash  (rsp_hash),
        .rsp_ready (rsp_ready)
    );

    function automatic logic [HASH_W-1:0] eng_model(input logic [DATA_W-1:0] k);
        logic [HASH_W-1:0] f;
        f = '0;
        for (int i = 0; i < 7; i++)
            f = f ^ HASH_W'(k >> (10*i));
        return f ^ (f << 7);
    endfunction

    assign eng_hash = eng_model(eng_data);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_rsp: got id %0d hash %0h expected none at %0t",
                         rsp_id, rsp_hash, $time);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_id", 64'(rsp_id), 64'(mon_e.id));
                check("rsp_hash", 64'(rsp_hash), 64'(mon_e.hash));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise one request, wait (bounded) for its grant, then drop it.
    task automatic do_req(input int id, input logic [63:0] key, input logic [9:0] h);
        bit got;
        got = 1'b0;
        req_data[id*DATA_W +: DATA_W] = key;
        req_valid[id] = 1'b1;
        sb.push_back('{id: ID_W'(id), hash: h});
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1'b1;
            else step();
        end
        check("grant_seen", 64'(got), 64'd1);
        check("grant_onehot", 64'(req_ready), 64'(1) << id);
        step();
        req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (sb.size() != 0 && c < 30) begin
            step();
            c++;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    logic [ID_W-1:0]   fair_id [5];
    logic [HASH_W-1:0] fair_h  [5];

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;

        // Reset then idle.
        @(negedge clk);
        check("in_reset_outputs", 64'({rsp_valid, rsp_id, rsp_hash, req_ready}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_outputs", 64'({rsp_valid, rsp_id, rsp_hash, req_ready}), 64'd0);
            check("idle_eng_data", 64'(eng_data), 64'd0);
            check("idle_state", 64'(dut.state_q), 64'(IDLE));
            step();
        end

        // Fairness: all four valid, keys 1..4.
        rsp_ready = 1'b1;
`ifdef HASH_ARB_PRIO0_EN
        fair_id = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        fair_h  = '{10'h081, 10'h081, 10'h081, 10'h081, 10'h081};
`else
        fair_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        fair_h  = '{10'h081, 10'h102, 10'h183, 10'h204, 10'h081};
`endif
        req_data  = {64'd4, 64'd3, 64'd2, 64'd1};
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            sb.push_back('{id: fair_id[g], hash: fair_h[g]});
            @(negedge clk);
            check("fair_grant", 64'(req_ready), 64'(1) << fair_id[g]);
            step();
            if (g == 4) req_valid = '0;
            @(negedge clk);
            check("fair_hash_cycle", 64'({rsp_valid, req_ready}), 64'd0);
            step();
            @(negedge clk);
            check("fair_resp_cycle", 64'({rsp_valid, req_ready}), 64'h10);
            step();
        end
        drain();

        // Single request on requester 2, key 1.
        do_req(2, 64'h1, 10'b0010000001);
        @(negedge clk);
        check("single_hash_cycle", 64'({rsp_valid, req_ready}), 64'd0);
        check("single_eng_data", 64'(eng_data), 64'h1);
        step();
        @(negedge clk);
        check("single_rsp_valid", 64'(rsp_valid), 64'd1);
        step();
        @(negedge clk);
        check("single_back_idle", 64'({rsp_valid, dut.state_q}), 64'(IDLE));
        step();

        // Backpressure on requester 3 (key 5), requester 0 waiting meanwhile.
        rsp_ready = 1'b0;
        do_req(3, 64'h5, 10'h285);
        step();
        req_data[0 +: DATA_W] = 64'h400;
        req_valid[0] = 1'b1;
        sb.push_back('{id: 2'd0, hash: 10'h081});
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_hold", 64'({rsp_valid, rsp_id, rsp_hash, req_ready}),
                  64'({1'b1, 2'd3, 10'h285, 4'b0000}));
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 64'(rsp_valid), 64'd1);
        step();
        @(negedge clk);
        check("bp_next_grant", 64'(req_ready), 64'b0001);
        step();
        req_valid = '0;
        drain();

        // Reset mid-HASH: requester 1 granted, then reset in HASH.
        req_data  = {64'd5, 64'd4, 64'd3, 64'd0};
        req_valid = 4'b0010;
        @(negedge clk);
        check("rst_pre_grant", 64'(req_ready), 64'b0010);
        step();
        req_valid = '0;
        #2 rst = 1'b1;
        #1;
        check("rst_async_valid", 64'(rsp_valid), 64'd0);
        check("rst_async_state", 64'(dut.state_q), 64'(IDLE));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("rst_no_rsp", 64'(rsp_valid), 64'd0);
            step();
        end
        // ptr back at 0: among 1..3 the search picks 1 (a stale ptr of 2 picks 2).
        req_valid = 4'b1110;
        sb.push_back('{id: 2'd1, hash: 10'h183});
        @(negedge clk);
        check("rst_ptr_zero", 64'(req_ready), 64'b0010);
        step();
        req_valid = '0;
        drain();

        // Requesters 0 and 1 continuously valid (ptr is 2 at this point).
        req_data  = {64'd0, 64'd0, 64'd2, 64'd1};
        req_valid = 4'b0011;
        for (int g = 0; g < 4; g++) begin
`ifdef HASH_ARB_PRIO0_EN
            sb.push_back('{id: 2'd0, hash: 10'h081});
            @(negedge clk);
            check("prio_grant", 64'(req_ready), 64'b0001);
`else
            sb.push_back('{id: ID_W'(g % 2), hash: (g % 2 == 0) ? 10'h081 : 10'h102});
            @(negedge clk);
            check("alt_grant", 64'(req_ready), 64'(1) << (g % 2));
`endif
            step();
            if (g == 3) req_valid = '0;
            step();
            step();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hash_arbiter.md
# hash_arbiter

Round-robin arbiter and sequencer that shares one combinational name-hash engine (64-bit key in, 10-bit hash out) among several lookup requesters in the NDN router (PIT, FIB, CS lookups). It accepts keys over per-requester valid/ready handshakes and presents each key to the engine for one cycle. It registers the resulting hash and returns it with the requester ID over a single valid/ready response channel.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_W, 64: key width.
- HASH_W, 10: hash width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester key valid.
- req_data  in  NUM_REQ*DATA_W  keys; requester i at bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot grant/accept.
- eng_data  out  DATA_W  key driven to hash engine.
- eng_hash  in  HASH_W  engine result, combinational from eng_data.
- rsp_valid  out  1  result valid.
- rsp_id  out  clog2(NUM_REQ)  requester index of result.
- rsp_hash  out  HASH_W  registered hash.
- rsp_ready  in  1  consumer accepts result.

## Operation
- FSM has three states: IDLE, HASH, RESP.
- IDLE:
  - If any req_valid is set, pick a winner using round-robin starting at pointer ptr.
  - Assert req_ready[winner] combinationally in the same cycle. The transfer is req_valid & req_ready.
  - Latch req_data[winner] into key_q and winner into id_q.
  - Set ptr = (winner+1) mod NUM_REQ and move to HASH.
  - With no request, stay in IDLE. req_ready is all zeros.
- HASH:
  - eng_data = key_q.
  - At the clock edge, capture eng_hash into hash_q and move to RESP.
  - req_ready is all zeros.
- RESP:
  - rsp_valid=1, rsp_id=id_q, rsp_hash=hash_q, all held stable.
  - When rsp_ready=1, move to IDLE. Otherwise stay in RESP (backpressure).
- req_ready is never asserted outside IDLE. At most one req_ready bit is high.
- Requesters hold req_valid and req_data stable until accepted. Dropping valid before acceptance removes the request.
- eng_data is driven with key_q in every state. In IDLE it holds the last key, which keeps the engine input quiet.
- The round-robin pointer advances only on an accepted grant.

## Timing
- Reset values:
  - state=IDLE, ptr=0, key_q=0, id_q=0, hash_q=0.
  - rsp_valid=0, rsp_id=0, rsp_hash=0, req_ready=0, eng_data=0.
- Reset asserted mid-operation aborts the in-flight request. Its result is lost, and the requester must re-request.
- Latency: grant in cycle T, rsp_valid high in cycle T+2.
- Minimum issue interval is 3 cycles (T, T+1, T+2 with rsp_ready=1). The next grant can occur at T+3.
- If req_valid and rsp_ready are high in the same RESP cycle, no grant is issued that cycle.
- The engine must settle within one clock period (single-cycle combinational path).
- The engine has a one-cycle post-reset warm-up. This is covered because the earliest possible HASH cycle is the second cycle after reset release.

## Configuration
- HASH_ARB_PRIO0_EN:
  - When defined: requester 0 has strict priority. If req_valid[0]=1 in IDLE, it wins regardless of ptr and ptr is not changed. Other requesters use round-robin among themselves as above.
  - When undefined: pure round-robin over all NUM_REQ requesters.

## Structure
- Package hash_arb_pkg contains:
  - state enum (IDLE, HASH, RESP);
  - default DATA_W / HASH_W constants shared with the hash engine;
  - ID_W = clog2(NUM_REQ) helper.
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, winner index, any.
  - It contains the HASH_ARB_PRIO0_EN masking.
- hash_arbiter instantiates rr_pick and holds the FSM and registers. The hash engine stays external.

## Test plan
- Reset then idle: hold rst 2 cycles, release with no requests. Required: all outputs 0 and state IDLE for 10 cycles.
- Single request: req_valid=4'b0100, key 64'h1 in cycle T. Required:
  - req_ready=4'b0100 at T;
  - rsp_valid at T+2 with rsp_id=2, rsp_hash = engine value for key 1 (10'b0010000001);
  - with rsp_ready=1, next idle at T+3.
- Fairness: all four req_valid held high, rsp_ready=1. Required: grant order 0,1,2,3,0 at 3-cycle spacing.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid. Required:
  - rsp_valid, rsp_id and rsp_hash stable;
  - req_ready stays 0 throughout;
  - completes on the cycle rsp_ready rises.
- Reset mid-HASH: assert rst while in HASH. Required: immediate rsp_valid=0 and ptr=0, with no response after release.
- HASH_ARB_PRIO0_EN: requesters 0 and 1 continuously valid. Required: requester 0 always granted. Without the macro, grants alternate 0,1.
